fmmu_xlat: RTL and testbench

Parametrised FMMU block: holds NUM_FMMU channel register sets at BASE_ADDR and translates logical datagram addresses into physical process-RAM byte addresses with bit masks. Unlike the fixed 16-channel combinational FMMU, translation runs through a two-stage pipeline with a valid/ready handshake and full back-pressure. Per-request outputs include lowest-index channel priority, a multi-hit flag and a per-byte bit mask. The block sits between the frame processor's logical-addressing path and the process-RAM arbiter; its register port hangs off the internal register FIFO bus.

---
 rtl/fmmu_xlat.sv | 251 +++++++++++++++++++++++++
 tb/tb_fmmu_xlat.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmmu_xlat.sv
// FMMU register bank plus a two-stage logical-to-physical address translator.
// Lowest-index channel wins; the response carries a multi-hit flag and a bit mask.
module fmmu_xlat #(
    parameter int          NUM_FMMU  = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        read,
    output logic        ready,
    output logic [7:0]  rdata,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_laddr,
    input  logic        req_rd,
    input  logic        req_wr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_hit,
    output logic        rsp_multi,
    output logic [3:0]  rsp_idx,
    output logic [15:0] rsp_paddr,
    output logic [7:0]  rsp_mask
);

    localparam int NREG = 13;

    logic [NUM_FMMU-1:0][NREG-1:0][7:0] cfg_q, cfg_d;
    logic [7:0]  rdata_q, rdata_d;

    logic [16:0] rel;
    logic [3:0]  reg_ch;
    logic [3:0]  reg_off;
    logic        reg_hit;
    logic [7:0]  rbyte;

    always_comb begin
        rel     = {1'b0, addr} - {1'b0, BASE_ADDR};
        reg_ch  = rel[7:4];
        reg_off = rel[3:0];
        reg_hit = ~rel[16] && (rel[15:4] < 12'(NUM_FMMU))
                  && (reg_off < 4'(NREG));
        cfg_d   = cfg_q;
        rbyte   = 8'h00;
        for (int c = 0; c < NUM_FMMU; c++) begin
            for (int k = 0; k < NREG; k++) begin
                if (reg_hit && reg_ch == 4'(c) && reg_off == 4'(k)) begin
                    rbyte = cfg_q[c][k];
                    if (valid && !read) begin
                        cfg_d[c][k] = wdata;
                    end
                end
            end
        end
        rdata_d = (valid && read) ? rbyte : 8'h00;
    end

    logic [NUM_FMMU-1:0]        hit_w;
    logic [NUM_FMMU-1:0][15:0]  off_w;

    always_comb begin
        logic [32:0] diff;
        logic [31:0] lstart;
        logic [15:0] len;
        hit_w  = '0;
        off_w  = '0;
        diff   = '0;
        lstart = '0;
        len    = '0;
        for (int i = 0; i < NUM_FMMU; i++) begin
            lstart = {cfg_q[i][3], cfg_q[i][2], cfg_q[i][1], cfg_q[i][0]};
            len    = {cfg_q[i][5], cfg_q[i][4]};
            // A borrow out of the 33-bit subtraction means laddr < lstart.
            diff     = {1'b0, req_laddr} - {1'b0, lstart};
            off_w[i] = diff[15:0];
            hit_w[i] = cfg_q[i][12][0]
                       && ((req_rd && cfg_q[i][11][0])
                           || (req_wr && cfg_q[i][11][1]))
                       && !diff[32]
                       && (diff[31:0] < {16'h0000, len});
        end
    end

    logic        sel_hit;
    logic        sel_multi;
    logic [3:0]  sel_idx;
    logic [15:0] sel_off;
    logic [15:0] sel_len;
    logic [15:0] sel_pst;
    logic [2:0]  sel_lbs;
    logic [2:0]  sel_lbe;

    always_comb begin
        sel_hit   = 1'b0;
        sel_multi = 1'b0;
        sel_idx   = '0;
        sel_off   = '0;
        sel_len   = '0;
        sel_pst   = '0;
        sel_lbs   = '0;
        sel_lbe   = '0;
        for (int i = 0; i < NUM_FMMU; i++) begin
            if (hit_w[i]) begin
                if (sel_hit) begin
                    sel_multi = 1'b1;
                end else begin
                    sel_hit = 1'b1;
                    sel_idx = 4'(i);
                    sel_off = off_w[i];
                    sel_len = {cfg_q[i][5], cfg_q[i][4]};
                    sel_pst = {cfg_q[i][9], cfg_q[i][8]};
                    sel_lbs = cfg_q[i][6][2:0];
                    sel_lbe = cfg_q[i][7][2:0];
                end
            end
        end
    end

    logic        s1_valid_q, s1_valid_d;
    logic        s1_hit_q,   s1_hit_d;
    logic        s1_multi_q, s1_multi_d;
    logic [3:0]  s1_idx_q,   s1_idx_d;
    logic [15:0] s1_off_q,   s1_off_d;
    logic [15:0] s1_pst_q,   s1_pst_d;
    logic [2:0]  s1_lbs_q,   s1_lbs_d;
    logic [2:0]  s1_lbe_q,   s1_lbe_d;
    logic        s1_first_q, s1_first_d;
    logic        s1_last_q,  s1_last_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_hit_q,   rsp_hit_d;
    logic        rsp_multi_q, rsp_multi_d;
    logic [3:0]  rsp_idx_q,   rsp_idx_d;
    logic [15:0] rsp_paddr_q, rsp_paddr_d;
    logic [7:0]  rsp_mask_q,  rsp_mask_d;

    logic        s2_adv;
    logic        s1_adv;
    logic        s2_load;
    logic [2:0]  lo;
    logic [2:0]  hi;
    logic [7:0]  mask_w;

    always_comb begin
        s2_adv = ~rsp_valid_q | rsp_ready;
        s1_adv = ~s1_valid_q | s2_adv;

        lo = s1_first_q ? s1_lbs_q : 3'd0;
        hi = s1_last_q ? s1_lbe_q : 3'd7;
        for (int b = 0; b < 8; b++) begin
            mask_w[b] = (3'(b) >= lo) && (3'(b) <= hi);
        end

        s1_valid_d = s1_valid_q;
        s1_hit_d   = s1_hit_q;
        s1_multi_d = s1_multi_q;
        s1_idx_d   = s1_idx_q;
        s1_off_d   = s1_off_q;
        s1_pst_d   = s1_pst_q;
        s1_lbs_d   = s1_lbs_q;
        s1_lbe_d   = s1_lbe_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        if (s1_adv) begin
            s1_valid_d = req_valid;
            if (req_valid) begin
                s1_hit_d   = sel_hit;
                s1_multi_d = sel_multi;
                s1_idx_d   = sel_idx;
                s1_off_d   = sel_off;
                s1_pst_d   = sel_pst;
                s1_lbs_d   = sel_lbs;
                s1_lbe_d   = sel_lbe;
                s1_first_d = (sel_off == 16'd0);
                s1_last_d  = (sel_off == sel_len - 16'd1);
            end
        end

        s2_load     = s1_valid_q & s1_hit_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_multi_d = rsp_multi_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_paddr_d = rsp_paddr_q;
        rsp_mask_d  = rsp_mask_q;
        if (s2_adv) begin
            rsp_valid_d = s1_valid_q;
            rsp_hit_d   = s2_load;
            rsp_multi_d = s2_load & s1_multi_q;
            rsp_idx_d   = s2_load ? s1_idx_q : 4'd0;
            rsp_paddr_d = s2_load ? (s1_pst_q + s1_off_q) : 16'd0;
            rsp_mask_d  = s2_load ? mask_w : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= '0;
            rdata_q     <= 8'h00;
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_multi_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_off_q    <= '0;
            s1_pst_q    <= '0;
            s1_lbs_q    <= '0;
            s1_lbe_q    <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_multi_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_paddr_q <= '0;
            rsp_mask_q  <= '0;
        end else begin
            cfg_q       <= cfg_d;
            rdata_q     <= rdata_d;
            s1_valid_q  <= s1_valid_d;
            s1_hit_q    <= s1_hit_d;
            s1_multi_q  <= s1_multi_d;
            s1_idx_q    <= s1_idx_d;
            s1_off_q    <= s1_off_d;
            s1_pst_q    <= s1_pst_d;
            s1_lbs_q    <= s1_lbs_d;
            s1_lbe_q    <= s1_lbe_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_multi_q <= rsp_multi_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_paddr_q <= rsp_paddr_d;
            rsp_mask_q  <= rsp_mask_d;
        end
    end

    assign ready     = 1'b1;
    assign rdata     = rdata_q;
    assign req_ready = s1_adv;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_multi = rsp_multi_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_paddr = rsp_paddr_q;
    assign rsp_mask  = rsp_mask_q;

endmodule

// File: tb/tb_fmmu_xlat.sv
// Directed bench for fmmu_xlat with NUM_FMMU=4.
// Expected responses are hand-computed from the channel configurations.
module tb_fmmu_xlat;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        read;
    logic        ready;
    logic [7:0]  rdata;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_laddr;
    logic        req_rd;
    logic        req_wr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic        rsp_multi;
    logic [3:0]  rsp_idx;
    logic [15:0] rsp_paddr;
    logic [7:0]  rsp_mask;

    int checks = 0;
    int errors = 0;

    fmmu_xlat #(.NUM_FMMU(4), .BASE_ADDR(16'h0600)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid(valid), .addr(addr), .wdata(wdata), .read(read),
        .ready(ready), .rdata(rdata),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_laddr(req_laddr), .req_rd(req_rd), .req_wr(req_wr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_multi(rsp_multi), .rsp_idx(rsp_idx),
        .rsp_paddr(rsp_paddr), .rsp_mask(rsp_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [29:0] rw(input logic h, input logic m,
                                       input logic [3:0] i,
                                       input logic [15:0] p,
                                       input logic [7:0] k);
        return {h, m, i, p, k};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        valid = 1'b1;
        read  = 1'b0;
        addr  = a;
        wdata = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        valid = 1'b1;
        read  = 1'b1;
        addr  = a;
        tick();
        d     = rdata;
        valid = 1'b0;
        read  = 1'b0;
    endtask

    task automatic cfg(input int ch, input logic [31:0] ls,
                       input logic [15:0] len, input logic [7:0] lbs,
                       input logic [7:0] lbe, input logic [15:0] ps,
                       input logic [7:0] typ, input logic [7:0] en);
        logic [15:0] b;
        b = 16'h0600 + 16'(16 * ch);
        wr(b + 16'd0, ls[7:0]);
        wr(b + 16'd1, ls[15:8]);
        wr(b + 16'd2, ls[23:16]);
        wr(b + 16'd3, ls[31:24]);
        wr(b + 16'd4, len[7:0]);
        wr(b + 16'd5, len[15:8]);
        wr(b + 16'd6, lbs);
        wr(b + 16'd7, lbe);
        wr(b + 16'd8, ps[7:0]);
        wr(b + 16'd9, ps[15:8]);
        wr(b + 16'd11, typ);
        wr(b + 16'd12, en);
    endtask

    task automatic xl(input string tag, input logic [31:0] la,
                      input logic r, input logic w,
                      input logic [29:0] exp);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_laddr = la;
        req_rd    = r;
        req_wr    = w;
        #1;
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        chk({tag, "_lat1"}, rsp_valid, 1'b0);
        tick();
        chk({tag, "_lat2"}, rsp_valid, 1'b1);
        chk(tag, rw(rsp_hit, rsp_multi, rsp_idx, rsp_paddr, rsp_mask), exp);
        tick();
    endtask

    logic [7:0]  d;
    logic [29:0] ref_w;
    logic [29:0] got[$];
    int          sent;
    logic        acc_req;
    logic        acc_rsp;
    logic [29:0] cur;

    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        addr      = '0;
        wdata     = '0;
        read      = 1'b0;
        req_valid = 1'b0;
        req_laddr = '0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_rsp", rw(rsp_hit, rsp_multi, rsp_idx, rsp_paddr, rsp_mask),
            30'h0);
        rst_n = 1'b1;
        tick();

        wr(16'h0634, 8'hA5);
        rd(16'h0634, d);
        chk("reg_rb", d, 8'hA5);
        tick();
        chk("reg_idle_zero", rdata, 8'h00);
        wr(16'h064D, 8'h5A);
        wr(16'h0640, 8'h77);
        wr(16'h060D, 8'h33);
        rd(16'h064D, d);
        chk("reg_064d", d, 8'h00);
        rd(16'h0640, d);
        chk("reg_0640", d, 8'h00);
        rd(16'h060D, d);
        chk("reg_reserved", d, 8'h00);

        cfg(0, 32'h0001_0000, 16'd4, 8'd0, 8'd0, 16'h1000, 8'h01, 8'h01);
        rd(16'h0609, d);
        chk("reg_pst_hi", d, 8'h10);
        xl("basic_hit", 32'h0001_0002, 1'b1, 1'b0,
           rw(1'b1, 1'b0, 4'd0, 16'h1002, 8'hFF));
        xl("basic_end", 32'h0001_0004, 1'b1, 1'b0, 30'h0);
        xl("basic_below", 32'h0000_FFFF, 1'b1, 1'b0, 30'h0);
        xl("basic_wr_type", 32'h0001_0002, 1'b0, 1'b1, 30'h0);

        wr(16'h0606, 8'd3);
        wr(16'h0607, 8'd5);
        xl("mask_first", 32'h0001_0000, 1'b1, 1'b0,
           rw(1'b1, 1'b0, 4'd0, 16'h1000, 8'hF8));
        xl("mask_last", 32'h0001_0003, 1'b1, 1'b0,
           rw(1'b1, 1'b0, 4'd0, 16'h1003, 8'h3F));
        wr(16'h0604, 8'd1);
        xl("mask_len1", 32'h0001_0000, 1'b1, 1'b0,
           rw(1'b1, 1'b0, 4'd0, 16'h1000, 8'h38));
        wr(16'h0606, 8'd6);
        wr(16'h0607, 8'd2);
        xl("mask_empty", 32'h0001_0000, 1'b1, 1'b0,
           rw(1'b1, 1'b0, 4'd0, 16'h1000, 8'h00));

        cfg(1, 32'h0000_0100, 16'd16, 8'd0, 8'd0, 16'h2000, 8'h01, 8'h01);
        cfg(2, 32'h0000_0080, 16'h0100, 8'd0, 8'd0, 16'h3000, 8'h03, 8'h01);
        xl("prio_multi", 32'h0000_0100, 1'b1, 1'b0,
           rw(1'b1, 1'b1, 4'd1, 16'h2000, 8'hFF));
        wr(16'h061B, 8'h02);
        xl("prio_type", 32'h0000_0100, 1'b1, 1'b0,
           rw(1'b1, 1'b0, 4'd2, 16'h3080, 8'hFF));
        xl("ch2_last_wr", 32'h0000_017F, 1'b0, 1'b1,
           rw(1'b1, 1'b0, 4'd2, 16'h30FF, 8'h01));
        xl("ch2_past_end", 32'h0000_0180, 1'b1, 1'b1, 30'h0);

        cfg(3, 32'h0000_0500, 16'd4, 8'd0, 8'd0, 16'hFFFF, 8'h01, 8'h01);
        xl("pwrap", 32'h0000_0502, 1'b1, 1'b0,
           rw(1'b1, 1'b0, 4'd3, 16'h0001, 8'hFF));

        // Back-pressure: consumer stalls for 5 cycles.
        rsp_ready = 1'b0;
        sent      = 0;
        ref_w     = '0;
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1;
            req_laddr = 32'h80 + 32'(sent);
            req_rd    = 1'b1;
            req_wr    = 1'b0;
            #1;
            acc_req = req_ready;
            tick();
            if (acc_req) sent++;
            cur = rw(rsp_hit, rsp_multi, rsp_idx, rsp_paddr, rsp_mask);
            if (c == 1) ref_w = cur;
            if (c > 1) chk("bp_stable", cur, ref_w);
        end
        chk("bp_accepted", sent, 2);
        chk("bp_req_ready", req_ready, 1'b0);
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        chk("bp_head", ref_w, rw(1'b1, 1'b0, 4'd2, 16'h3000, 8'hFF));

        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_valid = (sent < 6);
            req_laddr = 32'h80 + 32'(sent);
            #1;
            acc_req = req_valid && req_ready;
            acc_rsp = rsp_valid;
            cur = rw(rsp_hit, rsp_multi, rsp_idx, rsp_paddr, rsp_mask);
            tick();
            if (acc_req) sent++;
            if (acc_rsp) got.push_back(cur);
        end
        req_valid = 1'b0;
        req_rd    = 1'b0;
        chk("bp_sent", sent, 6);
        chk("bp_count", got.size(), 6);
        for (int j = 0; j < got.size(); j++) begin
            chk($sformatf("bp_rsp%0d", j), got[j],
                rw(1'b1, 1'b0, 4'd2, 16'h3000 + 16'(j), 8'hFF));
        end
        chk("bp_drained", rsp_valid, 1'b0);

        // Reset with two requests in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_rd    = 1'b1;
        req_laddr = 32'h80;
        tick();
        req_laddr = 32'h81;
        tick();
        req_valid = 1'b0;
        chk("rs_inflight_valid", rsp_valid, 1'b1);
        chk("rs_inflight_ready", req_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_rsp_valid", rsp_valid, 1'b0);
        chk("rs_req_ready", req_ready, 1'b1);
        chk("rs_rsp", rw(rsp_hit, rsp_multi, rsp_idx, rsp_paddr, rsp_mask),
            30'h0);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        chk("rs_no_rsp", rsp_valid, 1'b0);
        rd(16'h0634, d);
        chk("rs_reg_0634", d, 8'h00);
        rd(16'h062C, d);
        chk("rs_reg_062c", d, 8'h00);
        rd(16'h0609, d);
        chk("rs_reg_0609", d, 8'h00);
        chk("rs_req_ready_after", req_ready, 1'b1);
        xl("rs_cfg_gone", 32'h0000_0100, 1'b1, 1'b0, 30'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
